// File: rtl/burst_ram_initiator.sv
// Cache-line initiator for BurstRAM: one request becomes one cmd_en burst; read beats are gathered into a line.
// Optional read watchdog is built when BURST_RAM_INITIATOR_TIMEOUT_EN is defined.
module burst_ram_initiator #(
  parameter int DATA_BITWIDTH  = 64,
  parameter int DEPTH_BITWIDTH = 8,
  parameter int BURST_COUNT    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             req_valid,
  output logic                                             req_ready,
  input  logic                                             req_write,
  input  logic [DEPTH_BITWIDTH-$clog2(BURST_COUNT)-1:0]    req_addr,
  input  logic [DATA_BITWIDTH*BURST_COUNT-1:0]             req_wr_line,
  input  logic [DATA_BITWIDTH/8*BURST_COUNT-1:0]           req_wr_be,
  output logic                                             rsp_valid,
  output logic [DATA_BITWIDTH*BURST_COUNT-1:0]             rsp_rd_line,
  output logic                                             rsp_err,
  output logic                                             br_cmd,
  output logic                                             br_cmd_en,
  output logic [DEPTH_BITWIDTH-1:0]                        br_addr,
  output logic [DATA_BITWIDTH-1:0]                         br_wr_data,
  output logic [DATA_BITWIDTH/8-1:0]                       br_data_mask,
  input  logic [DATA_BITWIDTH-1:0]                         br_rd_data,
  input  logic                                             br_rd_data_valid,
  input  logic                                             br_busy
);
  localparam int BEAT_W = $clog2(BURST_COUNT);
  localparam int BE_W   = DATA_BITWIDTH / 8;
  localparam int LINE_W = DATA_BITWIDTH * BURST_COUNT;
  localparam int MASK_W = BE_W * BURST_COUNT;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_COUNT - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WR_BURST = 2'd1;
  localparam logic [1:0] S_RD_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP     = 2'd3;

  logic [1:0]               r_state;
  logic [BEAT_W-1:0]        r_beat;
  logic [LINE_W-1:0]        r_line;
  logic [MASK_W-1:0]        r_be;
  logic [LINE_W-1:0]        w_rd_line;
  logic [DATA_BITWIDTH-1:0] w_wr_beat;
  logic [BE_W-1:0]          w_wr_be;
  logic                     w_accept;
  logic                     w_rd_last;

  assign req_ready = rst_n && (r_state == S_IDLE) && !br_busy && !rsp_valid;
  assign w_accept  = req_valid && req_ready;
  assign w_rd_last = (r_state == S_RD_WAIT) && br_rd_data_valid && (r_beat == LAST_BEAT);
  assign w_wr_beat = r_line[r_beat*DATA_BITWIDTH +: DATA_BITWIDTH];
  assign w_wr_be   = r_be[r_beat*BE_W +: BE_W];

  always_comb begin
    w_rd_line = r_line;
    if (br_rd_data_valid)
      w_rd_line[r_beat*DATA_BITWIDTH +: DATA_BITWIDTH] = br_rd_data;
  end

`ifdef BURST_RAM_INITIATOR_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo;
  logic             r_err;
  logic             w_tmo_hit;
  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err   = r_err;
`else
  assign rsp_err = 1'b0;
`endif

  // Line buffer: write data for bursts, or the read line seeded with the previous response
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_line <= req_write ? req_wr_line : rsp_rd_line;
      r_be   <= req_wr_be;
    end else if (r_state == S_RD_WAIT) begin
      r_line <= w_rd_line;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_beat       <= '0;
      rsp_valid    <= 1'b0;
      rsp_rd_line  <= '0;
      br_cmd       <= 1'b0;
      br_cmd_en    <= 1'b0;
      br_addr      <= '0;
      br_wr_data   <= '0;
      br_data_mask <= '0;
`ifdef BURST_RAM_INITIATOR_TIMEOUT_EN
      r_tmo        <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      br_cmd_en    <= 1'b0;
      br_wr_data   <= '0;
      br_data_mask <= '1;
      rsp_valid    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            br_cmd_en <= 1'b1;
            br_cmd    <= req_write;
            br_addr   <= {req_addr, BEAT_W'(0)};
`ifdef BURST_RAM_INITIATOR_TIMEOUT_EN
            r_tmo     <= '0;
`endif
            // Beat 0 leaves together with the command strobe
            if (req_write) begin
              br_wr_data   <= req_wr_line[DATA_BITWIDTH-1:0];
              br_data_mask <= ~req_wr_be[BE_W-1:0];
              r_beat       <= BEAT_W'(1);
              r_state      <= S_WR_BURST;
            end else begin
              r_beat  <= '0;
              r_state <= S_RD_WAIT;
            end
          end
        end
        S_WR_BURST: begin
          // Beat counter wraps to zero once the last beat has been driven
          if (r_beat == '0) begin
            rsp_valid <= 1'b1;
            r_state   <= S_RESP;
`ifdef BURST_RAM_INITIATOR_TIMEOUT_EN
            r_err     <= 1'b0;
`endif
          end else begin
            br_wr_data   <= w_wr_beat;
            br_data_mask <= ~w_wr_be;
            r_beat       <= r_beat + BEAT_W'(1);
          end
        end
        S_RD_WAIT: begin
          if (br_rd_data_valid)
            r_beat <= r_beat + BEAT_W'(1);
          if (w_rd_last) begin
            rsp_valid   <= 1'b1;
            rsp_rd_line <= w_rd_line;
            r_state     <= S_RESP;
`ifdef BURST_RAM_INITIATOR_TIMEOUT_EN
            r_err       <= 1'b0;
          end else if (w_tmo_hit) begin
            rsp_valid   <= 1'b1;
            rsp_rd_line <= w_rd_line;
            r_err       <= 1'b1;
            r_state     <= S_RESP;
`endif
          end
`ifdef BURST_RAM_INITIATOR_TIMEOUT_EN
          r_tmo <= r_tmo + TMO_W'(1);
`endif
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_burst_ram_initiator.sv
// Bench for burst_ram_initiator: BurstRAM behavioural model, queue-based response scoreboard, directed vectors.
module tb_burst_ram_initiator;
  localparam int DW = 64;
  localparam int LW = 256;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid, req_ready, req_write;
  logic [5:0]     req_addr;
  logic [LW-1:0]  req_wr_line;
  logic [31:0]    req_wr_be;
  logic           rsp_valid, rsp_err;
  logic [LW-1:0]  rsp_rd_line;
  logic           br_cmd, br_cmd_en;
  logic [7:0]     br_addr;
  logic [DW-1:0]  br_wr_data, br_rd_data;
  logic [7:0]     br_data_mask;
  logic           br_rd_data_valid, br_busy;

  logic           m_valid = 1'b0, stray_v;
  logic [DW-1:0]  m_data = '0, stray_d;
  assign br_rd_data_valid = m_valid | stray_v;
  assign br_rd_data       = m_valid ? m_data : stray_d;

  burst_ram_initiator #(.DATA_BITWIDTH(64), .DEPTH_BITWIDTH(8), .BURST_COUNT(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wr_line(req_wr_line), .req_wr_be(req_wr_be), .rsp_valid(rsp_valid),
    .rsp_rd_line(rsp_rd_line), .rsp_err(rsp_err), .br_cmd(br_cmd), .br_cmd_en(br_cmd_en),
    .br_addr(br_addr), .br_wr_data(br_wr_data), .br_data_mask(br_data_mask), .br_rd_data(br_rd_data),
    .br_rd_data_valid(br_rd_data_valid), .br_busy(br_busy));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // BurstRAM model: 3-cycle read latency, configurable gap and beat count; logs write beats
  logic [DW-1:0] mem [0:255];
  logic [7:0]    mask_q[$];
  logic [DW-1:0] data_q[$];
  int cmd_en_cnt = 0, cmd_cyc = -1, last_beat_cyc = -1;
  int rd_active = 0, rd_base = 0, rd_k = 0, rd_wait = 0, rd_gap = 0, rd_limit = 4;
  int wr_left = 0, wr_k = 0, wr_base = 0;

  always @(negedge clk) begin
    m_valid = 1'b0;
    if (!rst_n) begin
      rd_active = 0;
      wr_left   = 0;
    end else begin
      if (br_cmd_en) begin
        cmd_en_cnt++;
        cmd_cyc = cyc;
      end
      if (br_cmd_en && br_cmd) begin
        wr_left = 5; wr_k = 0; wr_base = int'(br_addr);
      end
      if (wr_left > 0) begin
        mask_q.push_back(br_data_mask);
        data_q.push_back(br_wr_data);
        if (wr_k < 4)
          for (int b = 0; b < 8; b++)
            if (!br_data_mask[b]) mem[wr_base+wr_k][b*8 +: 8] = br_wr_data[b*8 +: 8];
        wr_k++;
        wr_left--;
      end
      if (br_cmd_en && !br_cmd) begin
        rd_active = 1; rd_base = int'(br_addr); rd_k = 0; rd_wait = 3;
      end else if (rd_active != 0) begin
        rd_wait--;
        if (rd_wait == 0) begin
          m_valid = 1'b1;
          m_data  = mem[rd_base+rd_k];
          rd_k++;
          last_beat_cyc = cyc;
          rd_wait = rd_gap + 1;
          if (rd_k >= rd_limit) rd_active = 0;
        end
      end
    end
  end

  // Scoreboard monitor
  typedef struct { logic [LW-1:0] line; logic err; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int rsp_count = 0, rsp_cyc = -1;

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      rsp_count++;
      rsp_cyc = cyc;
      if (exp_q.size() == 0) check("unexpected_rsp", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("rsp_line", rsp_rd_line, mon_e.line);
        check("rsp_err", rsp_err, mon_e.err);
      end
    end
  end

  task automatic issue(input logic wr, input logic [5:0] la, input logic [LW-1:0] line,
                       input logic [31:0] be, output int cmd_c);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = la; req_wr_line = line; req_wr_be = be;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = ~wr; req_addr = '1; req_wr_line = '1; req_wr_be = '0;
    cmd_c = cyc;
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_count < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("rsp_arrived", (rsp_count >= target), 1);
    @(negedge clk);
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_br_cmd"}, br_cmd, 0);
    check({tag, "_br_cmd_en"}, br_cmd_en, 0);
    check({tag, "_br_addr"}, br_addr, 0);
    check({tag, "_br_wr_data"}, br_wr_data, 0);
    check({tag, "_br_data_mask"}, br_data_mask, 0);
    check({tag, "_rsp_rd_line"}, rsp_rd_line, 0);
  endtask

  localparam logic [LW-1:0] L0  = {64'h4444444444444444, 64'h3333333333333333,
                                   64'h2222222222222222, 64'h1111111111111111};
  localparam logic [LW-1:0] WA  = {64'hA3A3A3A3A3A3A3A3, 64'hA2A2A2A2A2A2A2A2,
                                   64'hA1A1A1A1A1A1A1A1, 64'hA0A0A0A0A0A0A0A0};
  localparam logic [LW-1:0] WB  = {64'hB3B3B3B3B3B3B3B3, 64'hB2B2B2B2B2B2B2B2,
                                   64'hB1B1B1B1B1B1B1B1, 64'hB0B0B0B0B0B0B0B0};
  localparam logic [LW-1:0] L3B = {64'hA3A3A3A3A3A3A3A3, 64'hA2A2A2A2A2A2A2A2,
                                   64'hA1A1A1A1B1B1B1B1, 64'hA0A0A0A0A0A0A0A0};
  localparam logic [LW-1:0] LTO = {64'h4444444444444444, 64'h3333333333333333,
                                   64'hA1A1A1A1B1B1B1B1, 64'hA0A0A0A0A0A0A0A0};

  logic [7:0]    exp_mask [0:4];
  logic [DW-1:0] exp_data [0:4];

  initial begin
    int cmd_c, base_rsp, base_cmd;
    rst_n = 1'b0; br_busy = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = '0;
    req_wr_line = '0; req_wr_be = '0; stray_v = 1'b0; stray_d = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = 64'h1111111111111111; mem[1] = 64'h2222222222222222;
    mem[2] = 64'h3333333333333333; mem[3] = 64'h4444444444444444;

    repeat (3) @(negedge clk);
    check_idle_outs("reset");
    rst_n = 1'b1;

    // busy stall, then read line 0 accepted on the first free cycle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("busy_stall_ready", req_ready, 0);
    end
    exp_q.push_back('{L0, 1'b0});
    base_rsp = rsp_count; base_cmd = cmd_en_cnt;
    br_busy = 1'b0;
    #1 check("ready_after_busy", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cmd_c = cyc;
    wait_rsp(base_rsp + 1);
    check("rd0_cmd_cycle", cmd_cyc, cmd_c);
    check("rd0_br_cmd", br_cmd, 0);
    check("rd0_br_addr", br_addr, 8'h00);
    check("rd0_latency", rsp_cyc, last_beat_cyc + 1);
    repeat (5) @(negedge clk);
    check("rd0_cmd_en_once", cmd_en_cnt - base_cmd, 1);
    check("rd0_rsp_once", rsp_count - base_rsp, 1);

    // full write of line 3
    mask_q.delete(); data_q.delete();
    exp_q.push_back('{L0, 1'b0});
    base_rsp = rsp_count; base_cmd = cmd_en_cnt;
    issue(1'b1, 6'd3, WA, 32'hFFFF_FFFF, cmd_c);
    wait_rsp(base_rsp + 1);
    check("wr_cmd_cycle", cmd_cyc, cmd_c);
    check("wr_br_cmd", br_cmd, 1);
    check("wr_br_addr", br_addr, 8'h0C);
    check("wr_latency", rsp_cyc - cmd_cyc, 4);
    check("wr_cmd_en_once", cmd_en_cnt - base_cmd, 1);
    check("wr_log_len", mask_q.size(), 5);
    for (int k = 0; k < 4; k++) begin
      exp_mask[k] = 8'h00;
      exp_data[k] = WA[k*DW +: DW];
    end
    exp_mask[4] = 8'hFF; exp_data[4] = '0;
    for (int k = 0; k < 5; k++) begin
      if (mask_q.size() > 0) begin
        check("wr_mask_beat", mask_q.pop_front(), exp_mask[k]);
        check("wr_data_beat", data_q.pop_front(), exp_data[k]);
      end
    end

    exp_q.push_back('{WA, 1'b0});
    base_rsp = rsp_count;
    issue(1'b0, 6'd3, '0, '0, cmd_c);
    wait_rsp(base_rsp + 1);
    check("rd3_br_addr", br_addr, 8'h0C);
    check("rd3_latency", rsp_cyc, last_beat_cyc + 1);

    // partial write: only low 4 bytes of beat 1 enabled
    mask_q.delete(); data_q.delete();
    exp_q.push_back('{WA, 1'b0});
    base_rsp = rsp_count;
    issue(1'b1, 6'd3, WB, 32'h0000_0F00, cmd_c);
    wait_rsp(base_rsp + 1);
    exp_mask[0] = 8'hFF; exp_mask[1] = 8'hF0; exp_mask[2] = 8'hFF; exp_mask[3] = 8'hFF; exp_mask[4] = 8'hFF;
    for (int k = 0; k < 5; k++)
      if (mask_q.size() > 0) check("pwr_mask_beat", mask_q.pop_front(), exp_mask[k]);

    exp_q.push_back('{L3B, 1'b0});
    base_rsp = rsp_count;
    issue(1'b0, 6'd3, '0, '0, cmd_c);
    wait_rsp(base_rsp + 1);

    // stray beat in IDLE, then a read with one-cycle gaps between beats
    base_rsp = rsp_count;
    @(negedge clk);
    stray_v = 1'b1; stray_d = 64'hDEADBEEFDEADBEEF;
    @(negedge clk);
    stray_v = 1'b0;
    repeat (5) @(negedge clk);
    check("stray_no_rsp", rsp_count - base_rsp, 0);
    check("stray_line_kept", rsp_rd_line, L3B);

    rd_gap = 1;
    exp_q.push_back('{L0, 1'b0});
    issue(1'b0, 6'd0, '0, '0, cmd_c);
    wait_rsp(base_rsp + 1);
    check("gap_latency", rsp_cyc, last_beat_cyc + 1);
    rd_gap = 0;

`ifdef BURST_RAM_INITIATOR_TIMEOUT_EN
    rd_limit = 2;
    exp_q.push_back('{LTO, 1'b1});
    base_rsp = rsp_count;
    issue(1'b0, 6'd3, '0, '0, cmd_c);
    wait_rsp(base_rsp + 1);
    check("tmo_latency", rsp_cyc - cmd_cyc, 16);
    check("tmo_ready_after", req_ready, 1);
    rd_limit = 4;
`endif

    // reset in the middle of a read
    base_rsp = rsp_count;
    issue(1'b0, 6'd3, '0, '0, cmd_c);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1 check_idle_outs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray_d = 64'h0123456789ABCDEF;
    stray_v = 1'b1;
    repeat (4) @(negedge clk);
    stray_v = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_no_rsp", rsp_count - base_rsp, 0);
    check("midrst_ready", req_ready, 1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
